// File: rtl/sdm_pkg.sv
// sdm_pkg: shared types and constants for the linear interpolator in front of
// the sigma-delta modulator.
//   sdm_state_e : interpolator FSM states (IDLE, RUN, STARVE)
//   midscale()  : offset-binary midscale value 2^(w-1), the 50% duty code
package sdm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STARVE = 2'd2
    } sdm_state_e;

    function automatic logic [31:0] midscale(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sdm_interp_lin_if.sv
// sdm_interp_lin_if: upstream sample stream into the interpolator.
//   s_valid : sample valid (master -> slave)
//   s_data  : W-bit unsigned offset-binary sample (master -> slave)
//   s_ready : slave can take a sample this cycle (slave -> master)
interface sdm_interp_lin_if #(
    parameter int W = 12
) ();
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sdm_fifo.sv
// sdm_fifo: small synchronous FIFO holding samples for the interpolator.
// Registered storage, no fall-through: a word pushed in cycle t is visible on
// dout_o from t+1. Push is ignored when full, pop is ignored when empty.
//   clk_fast, rst_n : clock, async active-low reset (clears pointers/count)
//   push_i, din_i   : write request and data
//   pop_i           : read request, dout_o is the head word
//   full_o, empty_o : occupancy flags
//   level_o         : number of stored words
module sdm_fifo #(
    parameter  int W     = 12,
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_fast,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] CNT_ONE = LW'(1);
    localparam logic [LW-1:0] CNT_MAX = LW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CNT_MAX);
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage needs no reset: contents are only observed through cnt_q.
    always_ff @(posedge clk_fast) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/sdm_interp_lin.sv
// sdm_interp_lin: first-order (linear) interpolator between an upstream sample
// stream and a sigma-delta modulator running at clk_fast. Each input sample is
// a segment target; the output ramps from the previous target to the new one
// over N = 2^OSR_LOG2 cycles.
//   clk_fast, rst_n : clock, async active-low reset
//   enable          : run request, looked at only on segment boundaries
//   s (slave)       : sample stream (s_valid / s_data / s_ready = not full)
//   dout            : interpolated sample, registered, to modulator din
//   underrun        : one-cycle pulse after a boundary that found no sample
//   busy            : FSM is not IDLE
//   fifo_level      : input FIFO occupancy
module sdm_interp_lin
    import sdm_pkg::*;
#(
    parameter  int W          = 12,
    parameter  int OSR_LOG2   = 6,
    parameter  int FIFO_DEPTH = 4,
    localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk_fast,
    input  logic                    rst_n,
    input  logic                    enable,
    sdm_interp_lin_if.slave         s,
    output logic [W-1:0]            dout,
    output logic                    underrun,
    output logic                    busy,
    output logic [LW-1:0]           fifo_level
);

    localparam int              AW     = W + OSR_LOG2;
    localparam logic [31:0]     MID32  = midscale(W);
    localparam logic [W-1:0]    MID    = MID32[W-1:0];
    localparam logic [OSR_LOG2-1:0] PH_ONE = OSR_LOG2'(1);

    sdm_state_e            state_q;
    logic [OSR_LOG2-1:0]   phase_q;
    logic [W-1:0]          c_q;
    logic [W:0]            step_q;      // two's complement, x - c
    logic [AW-1:0]         acc_q;
    logic                  und_q;

    logic                  boundary;
    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [W-1:0]          fifo_dout;
    logic [W:0]            step_d;
    logic [AW-1:0]         step_ext, c_shift;

    sdm_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .push_i   (fifo_push),
        .din_i    (s.s_data),
        .pop_i    (fifo_pop),
        .dout_o   (fifo_dout),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .level_o  (fifo_level)
    );

    assign s.s_ready = ~fifo_full;
    assign fifo_push = s.s_valid & ~fifo_full;

    // Phase counter free-runs; all-ones is the last cycle of a segment.
    assign boundary = (phase_q == '1);
    assign fifo_pop = boundary & enable & ~fifo_empty;

    // Zero-extend both operands to W+1 bits, the difference is the signed slope.
    assign step_d   = {1'b0, fifo_dout} - {1'b0, c_q};
    assign step_ext = {{(OSR_LOG2-1){step_q[W]}}, step_q};
    assign c_shift  = {c_q, {OSR_LOG2{1'b0}}};

    // Each segment restarts acc exactly at c<<OSR_LOG2, so the ramp of N-1
    // steps stays between the two targets and never overflows.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            c_q     <= MID;
            step_q  <= '0;
            acc_q   <= {MID, {OSR_LOG2{1'b0}}};
            und_q   <= 1'b0;
        end else begin
            phase_q <= phase_q + PH_ONE;
            und_q   <= 1'b0;
            if (boundary) begin
                acc_q <= c_shift;
                if (!enable) begin
                    step_q  <= '0;
                    state_q <= IDLE;
                end else if (!fifo_empty) begin
                    c_q     <= fifo_dout;
                    step_q  <= step_d;
                    state_q <= RUN;
                end else begin
                    step_q <= '0;
                    // IDLE with nothing queued stays put; only a running
                    // stream can starve.
                    if (state_q != IDLE) begin
                        state_q <= STARVE;
                        und_q   <= 1'b1;
                    end
                end
            end else if (state_q == RUN) begin
                acc_q <= acc_q + step_ext;
            end
        end
    end

    assign dout     = acc_q[AW-1:OSR_LOG2];
    assign underrun = und_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sdm_interp_lin.sv
// tb_sdm_interp_lin: scoreboard bench for sdm_interp_lin (W=12, N=4, depth 4).
// A transaction-level model decides what happens at each boundary and pushes
// the N expected dout values of the next segment into a queue; every cycle
// pops one and compares, along with underrun, busy, fifo_level and s_ready.
module tb_sdm_interp_lin;

    localparam int W  = 12;
    localparam int O  = 2;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int LW = $clog2(D + 1);

    logic          clk_fast = 1'b0;
    logic          rst_n    = 1'b1;
    logic          enable   = 1'b0;
    logic [W-1:0]  dout;
    logic          underrun, busy;
    logic [LW-1:0] fifo_level;

    sdm_interp_lin_if #(.W(W)) s_if ();

    sdm_interp_lin #(
        .W          (W),
        .OSR_LOG2   (O),
        .FIFO_DEPTH (D)
    ) dut (
        .clk_fast   (clk_fast),
        .rst_n      (rst_n),
        .enable     (enable),
        .s          (s_if),
        .dout       (dout),
        .underrun   (underrun),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk_fast = ~clk_fast;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    int cur = 2048;     // current segment target
    int ph  = 0;        // phase the DUT holds during the coming cycle
    int st  = 0;        // 0 idle, 1 run, 2 starve
    int mq[$];          // FIFO contents
    int expq[$];        // expected dout, one entry per cycle
    bit und_exp;
    bit acc_ok;
    int n_und = 0;

    // One clock cycle: drive at negedge, model the coming posedge, check at
    // the following negedge.
    task automatic tick(input bit v, input int d, input bit en);
        bit push_ok;
        int x;
        s_if.s_valid = v;
        s_if.s_data  = d[W-1:0];
        enable       = en;
        push_ok = v && (mq.size() < D);
        chk("s_ready", s_if.s_ready, mq.size() < D);
        und_exp = 1'b0;
        if (ph == N - 1) begin
            if (en && mq.size() > 0) begin
                x = mq.pop_front();
                for (int k = 0; k < N; k++) expq.push_back((cur * N + k * (x - cur)) / N);
                cur = x;
                st  = 1;
            end else begin
                for (int k = 0; k < N; k++) expq.push_back(cur);
                if (!en) st = 0;
                else if (st != 0) begin
                    st = 2;
                    und_exp = 1'b1;
                end
            end
        end
        if (push_ok) mq.push_back(d);
        acc_ok = push_ok;
        @(posedge clk_fast);
        ph = (ph + 1) % N;
        @(negedge clk_fast);
        chk("dout", dout, (expq.size() > 0) ? expq.pop_front() : cur);
        chk("underrun", underrun, und_exp);
        chk("busy", busy, st != 0);
        chk("fifo_level", fifo_level, mq.size());
        if (underrun) n_und++;
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) tick(1'b0, 0, en);
    endtask

    // Hold valid until the model says the push was taken; bounded.
    task automatic send(input int d, input bit en);
        for (int i = 0; i < 64; i++) begin
            tick(1'b1, d, en);
            if (acc_ok) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    // Asynchronous reset away from any clock edge, checked before any edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        s_if.s_valid = 1'b0;
        #1;
        chk("rst_dout", dout, 2048);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready", s_if.s_ready, 1);
        cur = 2048; st = 0; ph = 0;
        mq.delete();
        expq.delete();
        @(negedge clk_fast);
        @(negedge clk_fast);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_dout", dout, 2048);
        chk("rst_ready", s_if.s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_level", fifo_level, 0);
        @(negedge clk_fast);
        @(negedge clk_fast);
        rst_n = 1'b1;

        // Idle with enable low: midscale held.
        idle(8, 1'b0);

        // Rising ramp to 2052, then starvation pulses once per boundary.
        tick(1'b1, 2052, 1'b1);
        idle(16, 1'b1);
        chk("underrun_count", n_und, 3);

        // Falling ramp to 100, then 100 -> 97 with floor truncation.
        send(100, 1'b1);
        send(97, 1'b1);
        idle(12, 1'b1);
        chk("c_after_fall", dout, 97);

        // Back to IDLE, then backpressure: four fit, fifth waits for a pop.
        idle(4, 1'b0);
        send(500, 1'b0);
        send(600, 1'b0);
        send(700, 1'b0);
        send(800, 1'b0);
        chk("full_level", fifo_level, 4);
        chk("full_ready", s_if.s_ready, 0);
        send(900, 1'b1);
        idle(6, 1'b1);

        // Drop enable mid-segment: segment completes, queue stays.
        u0 = n_und;
        idle(12, 1'b0);
        chk("no_underrun_on_drop", n_und, u0);
        chk("queued_kept", fifo_level, mq.size());

        // Reset in the middle of a running segment.
        idle(6, 1'b1);
        do_reset();
        send(2060, 1'b1);
        idle(12, 1'b1);
        chk("post_reset_target", dout, 2060);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
